// File: rtl/alu_mdu.sv
// alu_mdu: registered single-cycle ALU plus an iterative radix-2 multiply/divide unit with HI/LO.
// Build macro ALU_MDU_DIV_EN compiles the divider; without it DIV/DIVU act as single-cycle ops returning 0.
module alu_mdu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             flush,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             equal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             dbg_state
);
  localparam logic [4:0] OP_SLL   = 5'd0;
  localparam logic [4:0] OP_SRA   = 5'd1;
  localparam logic [4:0] OP_SRL   = 5'd2;
  localparam logic [4:0] OP_ADD   = 5'd5;
  localparam logic [4:0] OP_SUB   = 5'd6;
  localparam logic [4:0] OP_AND   = 5'd7;
  localparam logic [4:0] OP_OR    = 5'd8;
  localparam logic [4:0] OP_XOR   = 5'd9;
  localparam logic [4:0] OP_NOR   = 5'd10;
  localparam logic [4:0] OP_SLT   = 5'd11;
  localparam logic [4:0] OP_SLTU  = 5'd12;
  localparam logic [4:0] OP_MULT  = 5'd13;
  localparam logic [4:0] OP_MULTU = 5'd14;
  localparam logic [4:0] OP_DIV   = 5'd15;
  localparam logic [4:0] OP_DIVU  = 5'd16;
  localparam logic [4:0] OP_MFHI  = 5'd17;
  localparam logic [4:0] OP_MFLO  = 5'd18;
  localparam logic [4:0] OP_MTHI  = 5'd19;
  localparam logic [4:0] OP_MTLO  = 5'd20;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t             r_state, w_state_next;
  logic [SHW-1:0]     r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [2*WIDTH-1:0] r_acc;
  logic               r_neg_lo;
  logic               r_eq_pend;
  logic [WIDTH-1:0]   r_hi, r_lo, r_result;
  logic               r_equal, r_out_valid;
`ifdef ALU_MDU_DIV_EN
  logic               r_is_div;
  logic               r_neg_hi;
  logic [WIDTH:0]     w_rem_sh, w_diff;
  logic [2*WIDTH-1:0] w_div_next;
`endif

  logic [SHW-1:0]     w_shamt;
  logic [WIDTH-1:0]   w_alu;
  logic               w_is_mul, w_is_div, w_signed;
  logic               w_x_neg, w_y_neg;
  logic [WIDTH-1:0]   w_x_mag, w_y_mag;
  logic               w_accept, w_start;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next, w_prod, w_acc_next;
  logic [WIDTH-1:0]   w_fin_hi, w_fin_lo;

  // Handshake: a request transfers on in_valid && in_ready; flush in the same cycle cancels it.
  // Results are a one-cycle out_valid pulse with no backpressure.
  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state == S_BUSY);
  assign dbg_state = r_state;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign equal     = r_equal;
  assign hi        = r_hi;
  assign lo        = r_lo;

  assign w_shamt  = y[SHW-1:0];
  assign w_accept = in_valid && in_ready && !flush;
  assign w_start  = w_accept && (w_is_mul || w_is_div);

  always_comb begin
    w_is_mul = (op == OP_MULT) || (op == OP_MULTU);
`ifdef ALU_MDU_DIV_EN
    w_is_div = (op == OP_DIV) || (op == OP_DIVU);
`else
    w_is_div = 1'b0;
`endif
    w_signed = (op == OP_MULT) || (op == OP_DIV);
    w_x_neg  = w_signed && x[WIDTH-1];
    w_y_neg  = w_signed && y[WIDTH-1];
    w_x_mag  = w_x_neg ? -x : x;
    w_y_mag  = w_y_neg ? -y : y;
  end

  always_comb begin
    w_alu = '0;
    case (op)
      OP_SLL:  w_alu = x << w_shamt;
      OP_SRA:  w_alu = $signed(x) >>> w_shamt;
      OP_SRL:  w_alu = x >> w_shamt;
      OP_ADD:  w_alu = x + y;
      OP_SUB:  w_alu = x - y;
      OP_AND:  w_alu = x & y;
      OP_OR:   w_alu = x | y;
      OP_XOR:  w_alu = x ^ y;
      OP_NOR:  w_alu = ~(x | y);
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
      OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (x < y)};
      OP_MFHI: w_alu = r_hi;
      OP_MFLO: w_alu = r_lo;
      default: w_alu = '0;
    endcase
  end

  // One iteration step on magnitudes; the sign fix is applied only to the final step's output.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
    w_prod     = r_neg_lo ? -w_mul_next : w_mul_next;
    w_acc_next = w_mul_next;
    w_fin_hi   = w_prod[2*WIDTH-1:WIDTH];
    w_fin_lo   = w_prod[WIDTH-1:0];
`ifdef ALU_MDU_DIV_EN
    w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_diff     = w_rem_sh - {1'b0, r_a};
    w_div_next = w_diff[WIDTH] ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                               : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};
    if (r_is_div) begin
      w_acc_next = w_div_next;
      w_fin_lo   = r_neg_lo ? -w_div_next[WIDTH-1:0] : w_div_next[WIDTH-1:0];
      w_fin_hi   = r_neg_hi ? -w_div_next[2*WIDTH-1:WIDTH] : w_div_next[2*WIDTH-1:WIDTH];
    end
`endif
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_next = S_BUSY;
      S_BUSY: if (flush || (r_cnt == '0)) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_a         <= '0;
      r_acc       <= '0;
      r_neg_lo    <= 1'b0;
      r_eq_pend   <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_result    <= '0;
      r_equal     <= 1'b0;
      r_out_valid <= 1'b0;
`ifdef ALU_MDU_DIV_EN
      r_is_div    <= 1'b0;
      r_neg_hi    <= 1'b0;
`endif
    end else begin
      r_out_valid <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_start) begin
          r_cnt     <= SHW'(WIDTH - 1);
          r_eq_pend <= (x == y);
`ifdef ALU_MDU_DIV_EN
          r_is_div  <= w_is_div;
          r_neg_hi  <= w_x_neg;
          if (w_is_div) begin
            // A zero divisor yields an all-ones quotient magnitude; keep it unsigned.
            r_a      <= w_y_mag;
            r_acc    <= {{WIDTH{1'b0}}, w_x_mag};
            r_neg_lo <= (y != '0) && (w_x_neg ^ w_y_neg);
          end else
`endif
          begin
            r_a      <= w_x_mag;
            r_acc    <= {{WIDTH{1'b0}}, w_y_mag};
            r_neg_lo <= w_x_neg ^ w_y_neg;
          end
        end else if (w_accept) begin
          r_out_valid <= 1'b1;
          r_result    <= w_alu;
          r_equal     <= (x == y);
          if (op == OP_MTHI) r_hi <= x;
          if (op == OP_MTLO) r_lo <= x;
        end
      end else if (!flush) begin
        r_acc <= w_acc_next;
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == '0) begin
          r_hi        <= w_fin_hi;
          r_lo        <= w_fin_lo;
          r_result    <= w_fin_lo;
          r_equal     <= r_eq_pend;
          r_out_valid <= 1'b1;
        end
      end
    end
  end
endmodule
